// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder with valid/ready operand and result handshakes
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands plus a carry-in, one bit per clock.
//   A single full_adder is reused across WIDTH shift cycles. The result
//   {cout,sum} is registered and held until the consumer takes it.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   operand set offered
//   in_ready  out  block can accept operands (IDLE)
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in
//   out_valid out  result available (DONE)
//   out_ready in   consumer takes result
//   sum       out  registered WIDTH-bit sum
//   cout      out  registered carry-out
//   busy      out  high while shifting

module full_adder (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ c_i;
  assign c_o = (x_i & y_i) | (x_i & c_i) | (y_i & c_i);
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_shifted;

  full_adder u_fa (
    .x_i (a_sh_q[0]),
    .y_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_shifted = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sum_sh_d = sum_shifted;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Final bit: publish the completed sum directly from the adder path.
          sum_d   = sum_shifted;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Outputs decode straight from the state register, so reset forces them at once.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp;
  int n_fail;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned (W+1)-bit sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // Offer operands, wait for the result, stall, then take it.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input int stall, input bit rnd_ready,
                       output logic [W-1:0] r_sum, output logic r_cout);
    int lat;
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    out_ready = 1'b0;
    check("latency", 32'(lat), 32'(W));
    r_sum  = sum;
    r_cout = cout;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (out_valid !== 1'b1 || sum !== r_sum || cout !== r_cout) begin
        check("stall_hold", {out_valid, cout, sum}, {1'b1, r_cout, r_sum});
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] rs;
  logic         rc;
  logic [W:0]   e;
  logic [W-1:0] hs;
  logic         hc;

  initial begin
    n_cmp = 0; n_fail = 0;
    vecs[0] = '{a: 4'h7, b: 4'h9, cin: 1'b0, exp_sum: 4'h0, exp_cout: 1'b1};
    vecs[1] = '{a: 4'hF, b: 4'hF, cin: 1'b1, exp_sum: 4'hF, exp_cout: 1'b1};
    vecs[2] = '{a: 4'h0, b: 4'h0, cin: 1'b1, exp_sum: 4'h1, exp_cout: 1'b0};
    vecs[3] = '{a: 4'h5, b: 4'hA, cin: 1'b0, exp_sum: 4'hF, exp_cout: 1'b0};
    vecs[4] = '{a: 4'h8, b: 4'h8, cin: 1'b1, exp_sum: 4'h1, exp_cout: 1'b1};
    vecs[5] = '{a: 4'h0, b: 4'h0, cin: 1'b0, exp_sum: 4'h0, exp_cout: 1'b0};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    // out_ready while idle has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_ready_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_ready_out_valid", 32'(out_valid), 32'd0);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1, 1'b0, rs, rc);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
    end

    // Hold result for 10 cycles with out_ready low
    a = 4'h9; b = 4'hC; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    check("hold_valid", 32'(out_valid), 32'd1);
    hs = sum; hc = cout;
    check("hold_value", {hc, hs}, 32'h16);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_stable", {out_valid, cout, sum}, {1'b1, 1'b1, 4'h6});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_in_ready", 32'(in_ready), 32'd1);
    check("hold_release_out_valid", 32'(out_valid), 32'd0);
    check("hold_after_take_sum", {cout, sum}, 32'h16);

    // Second in_valid during SHIFT is ignored
    a = 4'h2; b = 4'h5; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 4'h3; b = 4'h1; cin = 1'b0; in_valid = 1'b1;
    check("shift_in_ready", 32'(in_ready), 32'd0);
    check("shift_busy", 32'(busy), 32'd1);
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();
    check("ignore_valid", 32'(out_valid), 32'd1);
    check("ignore_result", {cout, sum}, 32'h07);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset after the 2nd SHIFT cycle
    a = 4'h6; b = 4'h7; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (out_valid !== 1'b0) check("rst_no_result", 32'(out_valid), 32'd0);
    end
    // First edge after reset release accepts operands
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_op(4'hB, 4'h6, 1'b0, 2, 1'b0, rs, rc);
    check("post_rst_result", {rc, rs}, 32'h11);

    // Exhaustive against reference model with random stalls
    for (int k = 0; k < 512; k++) begin
      logic [W-1:0] xa, xb;
      logic         xc;
      xa = k[3:0]; xb = k[7:4]; xc = k[8];
      e = ref_add(xa, xb, xc);
      do_op(xa, xb, xc, int'($urandom_range(0, 3)), 1'b1, rs, rc);
      if ({rc, rs} !== e) check($sformatf("exh_%0h_%0h_%0h", xa, xb, xc), {rc, rs}, 32'(e));
      else n_cmp++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
